// File: rtl/efuse_access_arb.sv
// -----------------------------------------------------------------------------
// efuse_access_arb
//
// Shares the single 8-bit eFuse macro port between NREQ requesters. Requester 0
// (boot autoload) has fixed top priority; requesters 1..NREQ-1 are served
// round-robin. Each grant performs one byte read or one bit program, driving
// the macro addr/rden/pgmen/aen pins with the sequence
//   IDLE -> SETUP -> STROBE (N cycles) -> HOLD -> RESP -> IDLE
// and then returns a one-cycle tagged response. Program requests with a wrong
// unlock key (or while program-locked) are answered with an error and never
// touch the macro pins.
//
// Optional feature macro: EFUSE_ARB_PGM_LOCK_EN
//   defined   : sticky program lock set by lock_set, cleared only by rst.
//   undefined : lock_set is ignored, no lock flop.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_vld/req_wr    per-requester valid and op (1=program bit, 0=read byte)
//   req_addr          per-requester address, requester i at [8i+7:8i]
//   req_rdy           one-hot accept (combinational, IDLE only)
//   rsp_vld/rsp_id    one-cycle response strobe and requester index
//   rsp_err/rsp_rdata reject flag and read data (0 for program/error)
//   cfg_trd/cfg_tpgm  read/program strobe length in cycles (0 treated as 1)
//   cfg_password      program unlock key (16'h55AA)
//   lock_set          program-lock set pulse (optional feature only)
//   efuse_*_o         registered macro pins; efuse_rdata_i macro read data
//   busy              access in progress (state != IDLE)
// -----------------------------------------------------------------------------
module efuse_access_arb #(
  parameter int NREQ   = 3,
  parameter int TRD_W  = 6,
  parameter int TPGM_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_vld,
  output logic [NREQ-1:0]         req_rdy,
  input  logic [NREQ-1:0]         req_wr,
  input  logic [NREQ*8-1:0]       req_addr,
  output logic                    rsp_vld,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_err,
  output logic [7:0]              rsp_rdata,
  input  logic [TRD_W-1:0]        cfg_trd,
  input  logic [TPGM_W-1:0]       cfg_tpgm,
  input  logic [15:0]             cfg_password,
  input  logic                    lock_set,
  output logic [7:0]              efuse_addr_o,
  output logic                    efuse_rden_o,
  output logic                    efuse_pgmen_o,
  output logic                    efuse_aen_o,
  input  logic [7:0]              efuse_rdata_i,
  output logic                    busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int IW1 = IW + 1;
  localparam int CW  = (TRD_W > TPGM_W) ? TRD_W : TPGM_W;
  localparam logic [15:0] UNLOCK_KEY = 16'h55AA;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  id_q, id_d;
  logic           wr_q, wr_d;
  logic           err_q, err_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     rdata_q, rdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Registered outputs and their next values
  logic [7:0]     efuse_addr_q, efuse_addr_d;
  logic           efuse_rden_q, efuse_rden_d;
  logic           efuse_pgmen_q, efuse_pgmen_d;
  logic           efuse_aen_q, efuse_aen_d;
  logic           rsp_vld_q, rsp_vld_d;
  logic [IW-1:0]  rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic [7:0]     rsp_rdata_q, rsp_rdata_d;
  logic           busy_q, busy_d;

  logic           grant_vld_s;
  logic [IW-1:0]  grant_idx_s;
  logic [IW1-1:0] sum_s;
  logic [IW-1:0]  cand_s;
  logic           sel_wr_s;
  logic [7:0]     sel_addr_s;
  logic           accept_s;
  logic           reject_s;
  logic           lock_hit_s;
  logic           last_strobe_s;
  logic           pins_on_s;
  logic           rsp_on_s;
  logic [CW-1:0]  n_rd_s;
  logic [CW-1:0]  n_pgm_s;

`ifdef EFUSE_ARB_PGM_LOCK_EN
  logic lock_q;

  // Sticky program lock; only a reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (lock_set) begin
      lock_q <= 1'b1;
    end else begin
      lock_q <= lock_q;
    end
  end

  // A set pulse coincident with a program accept already rejects it
  assign lock_hit_s = lock_q | lock_set;
`else
  logic unused_lock_set_s;
  assign unused_lock_set_s = lock_set;
  assign lock_hit_s        = 1'b0;
`endif

  // Strobe length: a zero configuration still gives a one-cycle strobe
  assign n_rd_s  = (cfg_trd  == {TRD_W{1'b0}})  ? CW'(1) : CW'(cfg_trd);
  assign n_pgm_s = (cfg_tpgm == {TPGM_W{1'b0}}) ? CW'(1) : CW'(cfg_tpgm);

  // Arbitration: requester 0 first, then a cyclic scan of 1..NREQ-1 from ptr_q
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {IW{1'b0}};
    sum_s       = {IW1{1'b0}};
    cand_s      = {IW{1'b0}};
    if (req_vld[0]) begin
      grant_vld_s = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        sum_s = {1'b0, ptr_q} + IW1'(k);
        if (sum_s > IW1'(NREQ - 1)) begin
          sum_s = sum_s - IW1'(NREQ - 1);
        end else begin
          sum_s = sum_s;
        end
        cand_s = sum_s[IW-1:0];
        if (!grant_vld_s && req_vld[cand_s]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = cand_s;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Select the granted requester's op/address and form the one-hot accept
  always_comb begin
    sel_wr_s   = 1'b0;
    sel_addr_s = 8'h00;
    req_rdy    = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == IW'(i)) begin
        sel_wr_s   = req_wr[i];
        sel_addr_s = req_addr[8*i +: 8];
        req_rdy[i] = accept_s;
      end else begin
        req_rdy[i] = 1'b0;
      end
    end
  end

  assign accept_s      = (state_q == S_IDLE) && grant_vld_s && !rst;
  assign reject_s      = sel_wr_s && ((cfg_password != UNLOCK_KEY) || lock_hit_s);
  assign last_strobe_s = (state_q == S_STROBE) && (cnt_q == CW'(1));

  // State and datapath registers, plus the registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= IW'(1);
      id_q          <= {IW{1'b0}};
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= 8'h00;
      rdata_q       <= 8'h00;
      cnt_q         <= {CW{1'b0}};
      efuse_addr_q  <= 8'h00;
      efuse_rden_q  <= 1'b0;
      efuse_pgmen_q <= 1'b0;
      efuse_aen_q   <= 1'b0;
      rsp_vld_q     <= 1'b0;
      rsp_id_q      <= {IW{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= 8'h00;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      wr_q          <= wr_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      efuse_addr_q  <= efuse_addr_d;
      efuse_rden_q  <= efuse_rden_d;
      efuse_pgmen_q <= efuse_pgmen_d;
      efuse_aen_q   <= efuse_aen_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_id_q      <= rsp_id_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic; rejected programs skip straight to the response
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = reject_s ? S_RESP : S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: begin
        if (last_strobe_s) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_STROBE;
        end
      end
      S_HOLD:   state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: latch the request at accept, count the strobe, capture read data
  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      id_d    = grant_idx_s;
      wr_d    = sel_wr_s;
      err_d   = reject_s;
      addr_d  = sel_addr_s;
      rdata_d = 8'h00;
      // Strobe length is frozen here so later config writes cannot stretch it
      cnt_d   = sel_wr_s ? n_pgm_s : n_rd_s;
      if (grant_idx_s == {IW{1'b0}}) begin
        ptr_d = ptr_q;
      end else if (grant_idx_s == IW'(NREQ - 1)) begin
        ptr_d = IW'(1);
      end else begin
        ptr_d = grant_idx_s + IW'(1);
      end
    end else if (last_strobe_s) begin
      rdata_d = wr_q ? rdata_q : efuse_rdata_i;
    end else if (state_q == S_STROBE) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state so every pin comes straight from a flop
  always_comb begin
    pins_on_s     = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    rsp_on_s      = (state_d == S_RESP);
    efuse_addr_d  = pins_on_s ? addr_d : 8'h00;
    efuse_rden_d  = pins_on_s && !wr_d;
    efuse_pgmen_d = pins_on_s && wr_d;
    efuse_aen_d   = (state_d == S_STROBE);
    rsp_vld_d     = rsp_on_s;
    rsp_id_d      = rsp_on_s ? id_d : {IW{1'b0}};
    rsp_err_d     = rsp_on_s && err_d;
    if (rsp_on_s && !err_d && !wr_d) begin
      rsp_rdata_d = rdata_d;
    end else begin
      rsp_rdata_d = 8'h00;
    end
    busy_d        = (state_d != S_IDLE);
  end

  assign efuse_addr_o  = efuse_addr_q;
  assign efuse_rden_o  = efuse_rden_q;
  assign efuse_pgmen_o = efuse_pgmen_q;
  assign efuse_aen_o   = efuse_aen_q;
  assign rsp_vld       = rsp_vld_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_efuse_access_arb.sv
// -----------------------------------------------------------------------------
// Self-checking bench for efuse_access_arb (NREQ=3, TRD_W=6, TPGM_W=10).
// A transaction-timeline model (accept cycle T, strobe length N) predicts every
// output each cycle; directed scenarios add literal expectations on top, then
// a randomized phase exercises arbitration, rejects, resets and config churn.
// -----------------------------------------------------------------------------
module tb_efuse_access_arb;

  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_vld;
  logic [2:0]  req_rdy;
  logic [2:0]  req_wr;
  logic [23:0] req_addr;
  logic        rsp_vld;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  logic [5:0]  cfg_trd;
  logic [9:0]  cfg_tpgm;
  logic [15:0] cfg_password;
  logic        lock_set;
  logic [7:0]  efuse_addr_o;
  logic        efuse_rden_o;
  logic        efuse_pgmen_o;
  logic        efuse_aen_o;
  logic [7:0]  efuse_rdata_i;
  logic        busy;

  int tests = 0;
  int fails = 0;

  efuse_access_arb dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cfg_trd(cfg_trd), .cfg_tpgm(cfg_tpgm), .cfg_password(cfg_password),
    .lock_set(lock_set),
    .efuse_addr_o(efuse_addr_o), .efuse_rden_o(efuse_rden_o),
    .efuse_pgmen_o(efuse_pgmen_o), .efuse_aen_o(efuse_aen_o),
    .efuse_rdata_i(efuse_rdata_i), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: one outstanding transaction described by its accept
  // cycle and strobe length; outputs follow from the offset d = cycle - T.
  // ---------------------------------------------------------------------------
  int          mc = 0;
  bit          m_act = 1'b0;
  bit          m_rej = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_lock = 1'b0;
  bit          m_rst_pend = 1'b0;
  int          m_T = 0;
  int          m_N = 1;
  int          m_id = 0;
  int          m_ptr = 1;
  logic [7:0]  m_addr = 8'h00;
  logic [7:0]  m_rdata = 8'h00;

  always @(negedge clk) begin
    int d;
    int g;
    int c;
    bit pins;
    bit rsp;
    bit bsy;
    bit lock_eff;
    logic [2:0] e_rdy;
    #2;
    mc++;
    if (m_rst_pend) begin
      m_act  = 1'b0;
      m_ptr  = 1;
      m_lock = 1'b0;
    end
    m_rst_pend = rst;
    d = mc - m_T;
    if (m_act && d >= (m_rej ? 2 : m_N + 4)) m_act = 1'b0;
    pins = m_act && !m_rej && d >= 1 && d <= m_N + 2;
    rsp  = m_act && (m_rej ? (d == 1) : (d == m_N + 3));
    bsy  = m_act && d >= 1 && (m_rej ? (d == 1) : (d <= m_N + 3));
    if (m_act && !m_rej && !m_wr && d == m_N + 1) m_rdata = efuse_rdata_i;

    e_rdy = 3'b000;
    g = -1;
    if (!m_act && !rst) begin
      if (req_vld[0]) g = 0;
      else begin
        for (int k = 0; k < NREQ - 1; k++) begin
          c = 1 + ((m_ptr - 1 + k) % (NREQ - 1));
          if (g < 0 && req_vld[c]) g = c;
        end
      end
      if (g >= 0) e_rdy[g] = 1'b1;
    end

    chk("req_rdy",   req_rdy,       e_rdy);
    chk("addr",      efuse_addr_o,  pins ? m_addr : 8'h00);
    chk("rden",      efuse_rden_o,  pins && !m_wr);
    chk("pgmen",     efuse_pgmen_o, pins && m_wr);
    chk("aen",       efuse_aen_o,   m_act && !m_rej && d >= 2 && d <= m_N + 1);
    chk("rsp_vld",   rsp_vld,       rsp);
    chk("rsp_id",    rsp_id,        rsp ? m_id : 0);
    chk("rsp_err",   rsp_err,       rsp && m_rej);
    chk("rsp_rdata", rsp_rdata,     (rsp && !m_rej && !m_wr) ? m_rdata : 8'h00);
    chk("busy",      busy,          bsy);

`ifdef EFUSE_ARB_PGM_LOCK_EN
    lock_eff = m_lock || lock_set;
`else
    lock_eff = 1'b0;
`endif
    if (g >= 0) begin
      m_act   = 1'b1;
      m_T     = mc;
      m_id    = g;
      m_wr    = req_wr[g];
      m_addr  = req_addr[8*g +: 8];
      m_N     = m_wr ? max1(int'(cfg_tpgm)) : max1(int'(cfg_trd));
      m_rej   = m_wr && ((cfg_password != 16'h55AA) || lock_eff);
      m_rdata = 8'h00;
      if (g > 0) m_ptr = (g == NREQ - 1) ? 1 : g + 1;
    end
`ifdef EFUSE_ARB_PGM_LOCK_EN
    m_lock = m_lock || lock_set;
`endif
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_req(input int i, input bit wr, input logic [7:0] a);
    req_vld[i]         = 1'b1;
    req_wr[i]          = wr;
    req_addr[8*i +: 8] = a;
  endtask

  task automatic adv(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    req_vld  = 3'b000;
    lock_set = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for requester i to be accepted; returns at negedge+1 of T
  task automatic wait_acc(input int i, input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      #1;
      if (req_rdy[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: no accept for requester %0d within bound", nm, i);
    end
  endtask

  function automatic int onehot_idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  int   order [6];
  int   gcnt;
  bit   drop0;
  logic [2:0] acc_prev;

  initial begin
    rst           = 1'b1;
    req_vld       = 3'b000;
    req_wr        = 3'b000;
    req_addr      = 24'h000000;
    cfg_trd       = 6'd4;
    cfg_tpgm      = 10'd4;
    cfg_password  = 16'h55AA;
    lock_set      = 1'b0;
    efuse_rdata_i = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_vld", rsp_vld, 1'b0);
    chk("reset_rdy", req_rdy, 3'b000);

    // 1: read, N=9
    do_reset();
    cfg_trd = 6'd9;
    efuse_rdata_i = 8'h5A;
    set_req(1, 1'b0, 8'h23);
    wait_acc(1, "t1");
    adv(1); req_vld = 3'b000;
    chk("t1_rden_setup", efuse_rden_o, 1'b1);
    chk("t1_addr_setup", efuse_addr_o, 8'h23);
    chk("t1_aen_setup", efuse_aen_o, 1'b0);
    adv(1); chk("t1_aen_first", efuse_aen_o, 1'b1);
    adv(8); chk("t1_aen_last", efuse_aen_o, 1'b1);
    adv(1); chk("t1_aen_hold", efuse_aen_o, 1'b0);
    chk("t1_rden_hold", efuse_rden_o, 1'b1);
    adv(1); chk("t1_rsp_vld", rsp_vld, 1'b1);
    chk("t1_rsp_id", rsp_id, 2'd1);
    chk("t1_rsp_rdata", rsp_rdata, 8'h5A);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_rden_resp", efuse_rden_o, 1'b0);

    // 2: program, N=60
    do_reset();
    cfg_tpgm = 10'd60;
    set_req(2, 1'b1, 8'h81);
    wait_acc(2, "t2");
    adv(1); req_vld = 3'b000;
    chk("t2_pgmen_setup", efuse_pgmen_o, 1'b1);
    chk("t2_rden_setup", efuse_rden_o, 1'b0);
    adv(1); chk("t2_aen_first", efuse_aen_o, 1'b1);
    adv(59); chk("t2_aen_last", efuse_aen_o, 1'b1);
    adv(1); chk("t2_aen_hold", efuse_aen_o, 1'b0);
    chk("t2_pgmen_hold", efuse_pgmen_o, 1'b1);
    adv(1); chk("t2_rsp_vld", rsp_vld, 1'b1);
    chk("t2_rsp_err", rsp_err, 1'b0);
    chk("t2_rsp_rdata", rsp_rdata, 8'h00);
    chk("t2_rsp_id", rsp_id, 2'd2);
    chk("t2_pgmen_resp", efuse_pgmen_o, 1'b0);

    // 3: bad password -> reject
    do_reset();
    cfg_password = 16'h1234;
    set_req(1, 1'b1, 8'h07);
    wait_acc(1, "t3");
    adv(1); req_vld = 3'b000;
    chk("t3_rsp_vld", rsp_vld, 1'b1);
    chk("t3_rsp_err", rsp_err, 1'b1);
    chk("t3_busy", busy, 1'b1);
    chk("t3_pgmen", efuse_pgmen_o, 1'b0);
    chk("t3_aen", efuse_aen_o, 1'b0);
    adv(1); chk("t3_busy_after", busy, 1'b0);
    cfg_password = 16'h55AA;

    // 4: round robin with requester 0 priority
    do_reset();
    cfg_trd = 6'd2;
    set_req(0, 1'b0, 8'h10);
    set_req(1, 1'b0, 8'h11);
    set_req(2, 1'b0, 8'h12);
    gcnt = 0;
    drop0 = 1'b0;
    for (int n = 0; n < 300 && gcnt < 6; n++) begin
      if (n > 0) @(negedge clk);
      if (drop0) begin req_vld[0] = 1'b0; drop0 = 1'b0; end
      if (gcnt == 5) req_vld[0] = 1'b1;
      #1;
      if (req_rdy != 3'b000) begin
        order[gcnt] = onehot_idx(req_rdy);
        if (gcnt == 0) drop0 = 1'b1;
        gcnt++;
      end
    end
    if (gcnt < 6) begin
      tests++;
      fails++;
      $display("FAIL t4_grants: only %0d of 6 grants seen", gcnt);
    end else begin
      chk("t4_g0", order[0], 0);
      chk("t4_g1", order[1], 1);
      chk("t4_g2", order[2], 2);
      chk("t4_g3", order[3], 1);
      chk("t4_g4", order[4], 2);
      chk("t4_g5_reraise", order[5], 0);
    end
    adv(1); req_vld = 3'b000;

    // 5: cfg_trd=0 and reset during a program strobe
    do_reset();
    cfg_trd = 6'd0;
    set_req(1, 1'b0, 8'h10);
    wait_acc(1, "t5r");
    adv(1); req_vld = 3'b000;
    adv(1); chk("t5_aen_one", efuse_aen_o, 1'b1);
    adv(1); chk("t5_aen_hold", efuse_aen_o, 1'b0);
    adv(1); chk("t5_rsp_vld", rsp_vld, 1'b1);
    cfg_tpgm = 10'd20;
    set_req(2, 1'b1, 8'h44);
    wait_acc(2, "t5p");
    adv(1); req_vld = 3'b000;
    adv(4); chk("t5_mid_strobe", efuse_aen_o, 1'b1);
    rst = 1'b1;
    set_req(1, 1'b0, 8'h11);
    #1; chk("t5_rdy_in_rst", req_rdy, 3'b000);
    adv(1);
    rst = 1'b0;
    set_req(2, 1'b0, 8'h22);
    #1;
    chk("t5_post_aen", efuse_aen_o, 1'b0);
    chk("t5_post_pgmen", efuse_pgmen_o, 1'b0);
    chk("t5_post_addr", efuse_addr_o, 8'h00);
    chk("t5_post_busy", busy, 1'b0);
    chk("t5_post_rsp", rsp_vld, 1'b0);
    chk("t5_ptr_reset", req_rdy, 3'b010);
    adv(1); req_vld = 3'b000;
    adv(30);

    // 6: program lock
    do_reset();
    cfg_tpgm = 10'd3;
    lock_set = 1'b1;
    adv(1); lock_set = 1'b0;
    set_req(1, 1'b1, 8'h3C);
    wait_acc(1, "t6p");
    adv(1); req_vld = 3'b000;
`ifdef EFUSE_ARB_PGM_LOCK_EN
    chk("t6_lock_rsp", rsp_vld, 1'b1);
    chk("t6_lock_err", rsp_err, 1'b1);
    chk("t6_lock_pgmen", efuse_pgmen_o, 1'b0);
    adv(1);
    cfg_trd = 6'd1;
    efuse_rdata_i = 8'hC3;
    set_req(2, 1'b0, 8'h3D);
    wait_acc(2, "t6r");
    adv(1); req_vld = 3'b000;
    adv(3); chk("t6_read_vld", rsp_vld, 1'b1);
    chk("t6_read_data", rsp_rdata, 8'hC3);
    chk("t6_read_err", rsp_err, 1'b0);
`else
    chk("t6_nolock_pgmen", efuse_pgmen_o, 1'b1);
    adv(5); chk("t6_nolock_rsp", rsp_vld, 1'b1);
    chk("t6_nolock_err", rsp_err, 1'b0);
`endif
    adv(2);

    // Randomized phase
    do_reset();
    acc_prev = 3'b000;
    for (int n = 0; n < 2500; n++) begin
      if (n > 0) @(negedge clk);
      rst           = ($urandom_range(0, 249) == 0);
      lock_set      = ($urandom_range(0, 399) == 0);
      efuse_rdata_i = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        cfg_trd      = 6'($urandom_range(0, 5));
        cfg_tpgm     = 10'($urandom_range(0, 8));
        cfg_password = ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'h55AA;
      end
      for (int i = 0; i < 3; i++) begin
        if (!(req_vld[i] && !acc_prev[i])) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 1'($urandom_range(0, 1)), 8'($urandom));
          else req_vld[i] = 1'b0;
        end
      end
      #1;
      acc_prev = req_rdy;
    end

    rst = 1'b0;
    req_vld = 3'b000;
    repeat (30) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/efuse_access_arb.md
Name: efuse_access_arb

Overview:
Shares the single 8-bit eFuse macro port between several requesters: boot autoload (requester 0), register/manual path and trim-update engines (requesters 1..NREQ-1). Arbitrates the requests, sequences the macro's addr/rden/pgmen/aen timing for one byte read or one bit program per grant, and returns a tagged response. Sits between the requesters and the eFuse macro pins.

Parameters:
NREQ, 3, number of requesters (≥2); requester 0 has fixed top priority.
TRD_W, 6, width of read strobe length config.
TPGM_W, 10, width of program strobe length config.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_vld  in  NREQ  per-requester request valid
req_rdy  out  NREQ  one-hot accept; combinational
req_wr  in  NREQ  per-requester op: 1=program bit, 0=read byte
req_addr  in  NREQ*8  per-requester address, requester i at [8i+7:8i]
rsp_vld  out  1  one-cycle response strobe
rsp_id  out  $clog2(NREQ)  index of the requester being answered
rsp_err  out  1  request rejected; no macro access
rsp_rdata  out  8  read data; 0 for program or error responses
cfg_trd  in  TRD_W  read strobe length in cycles
cfg_tpgm  in  TPGM_W  program strobe length in cycles
cfg_password  in  16  program unlock key; must equal 16'h55AA
lock_set  in  1  program-lock set pulse (used only with optional feature)
efuse_addr_o  out  8  macro address
efuse_rden_o  out  1  macro read enable
efuse_pgmen_o  out  1  macro program enable
efuse_aen_o  out  1  macro access strobe
efuse_rdata_i  in  8  macro read data
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = 1. Reset during any state aborts the access. The next cycle has all macro pins low, no rsp_vld for the aborted request, and req_rdy=0 while rst=1.
- Arbitration happens only in IDLE. If req_vld[0]=1, requester 0 wins. Otherwise the first valid requester at or after the pointer wins, scanning 1..NREQ-1 cyclically. After a grant to i≥1, the pointer becomes i+1, wrapping to 1. Granting requester 0 leaves the pointer unchanged.
- req_rdy[i]=1 only in the accept cycle. The requester holds req_vld, req_wr and req_addr stable until accepted. At accept, id/op/addr are latched.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE.
  - SETUP (1 cycle): efuse_addr_o is driven; rden (read) or pgmen (program) asserts.
  - STROBE: aen=1 for N cycles. N = max(cfg_trd,1) for a read, max(cfg_tpgm,1) for a program. N is sampled at SETUP entry, so config changes mid-access are ignored.
  - HOLD (1 cycle): aen=0; addr and rden/pgmen still held.
  - RESP (1 cycle): rsp_vld=1 with rsp_id/rsp_err/rsp_rdata; all macro pins 0.
- Read data: efuse_rdata_i is registered on the last STROBE cycle.
- Latency, accept at cycle T: SETUP T+1, STROBE T+2..T+1+N, HOLD T+2+N, rsp_vld at T+3+N. The earliest next accept is T+4+N.
- Reject path: a program request with cfg_password≠16'h55AA (or a lock hit) is accepted, then goes IDLE->RESP directly. rsp_vld at T+1 with rsp_err=1; no macro pin toggles.
- Read requests are never rejected.
- All macro outputs are registered and glitch-free; rden and pgmen are never high together.

Optional Feature:
EFUSE_ARB_PGM_LOCK_EN
- Defined: a sticky lock flop is set by a lock_set pulse and cleared only by rst. While the lock is set, every program request takes the reject path (rsp_err=1). Reads are unaffected. A lock_set arriving in the same cycle as a program accept rejects that request.
- Undefined: lock_set is ignored and no lock flop exists.

Test Plan:
1. cfg_trd=9, requester 1 reads addr 0x23, efuse_rdata_i=0x5A, accept at T -> aen high T+2..T+10, rsp_vld at T+12 with id=1, rdata=0x5A, err=0, rden low at T+12.
2. cfg_tpgm=60, password 55AA, requester 2 programs addr 0x81 -> pgmen high T+1..T+62, aen high 60 cycles, rsp_vld at T+63 with err=0, rdata=0.
3. Password 0x1234, program request -> rsp_vld at T+1 with err=1; aen/pgmen never assert; busy high for one cycle.
4. Requesters 0, 1, 2 all hold reads continuously; requester 0 drops after its first grant -> grant order 0,1,2,1,2. Re-raise req_vld[0] -> 0 wins the next arbitration.
5. cfg_trd=0 -> STROBE is 1 cycle; rsp_vld at T+4. Assert rst mid-STROBE of a program -> next cycle all outputs 0, no response, pointer=1.
6. EFUSE_ARB_PGM_LOCK_EN defined: pulse lock_set, then program with valid password -> err=1, no pgmen; a subsequent read still returns data. Undefined: the same program proceeds normally.
